// File: rtl/dino_input_conditioner_pkg.sv
// Shared types and helpers for the push-button input conditioner.
// State encodings and channel indices are fixed so debug captures decode consistently.
package dino_input_conditioner_pkg;

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } db_state_t;

   localparam int BTN_JUMP = 0;
   localparam int BTN_HALT = 1;
   localparam int BTN_DBG  = 2;

   localparam int GLITCH_W = 8;

   function automatic logic [GLITCH_W-1:0] sat_add(input logic [GLITCH_W-1:0] acc,
                                                   input logic [GLITCH_W-1:0] inc);
      logic [GLITCH_W:0] sum;
      sum = {1'b0, acc} + {1'b0, inc};
      return sum[GLITCH_W] ? {GLITCH_W{1'b1}} : sum[GLITCH_W-1:0];
   endfunction

endpackage

// File: rtl/dino_input_conditioner_if.sv
// Button pad inputs and conditioned outputs between the pads/config and one game.
interface dino_input_conditioner_if #(
   parameter int N_CH = 3
);
   logic [N_CH-1:0] btn_raw;
   logic            cfg_bypass;
   logic [N_CH-1:0] btn_level;
   logic [N_CH-1:0] btn_rise;
   logic [N_CH-1:0] btn_fall;
   logic [7:0]      dbg_glitch_count;

   modport master (
      output btn_raw, cfg_bypass,
      input  btn_level, btn_rise, btn_fall, dbg_glitch_count
   );

   modport slave (
      input  btn_raw, cfg_bypass,
      output btn_level, btn_rise, btn_fall, dbg_glitch_count
   );
endinterface

// File: rtl/dino_input_conditioner_debounce_channel.sv
// One button channel: 2FF synchronizer, debounce FSM with qualification counter, edge pulses.
//
//   state        | meaning
//   RELEASED     | level 0, input stable low
//   PRESS_WAIT   | level 0, counting consecutive high samples
//   PRESSED      | level 1, input stable high
//   RELEASE_WAIT | level 1, counting consecutive low samples
module dino_input_conditioner_debounce_channel
   import dino_input_conditioner_pkg::*;
#(
   parameter int DB_CYCLES = 20000
) (
   input  logic clk,
   input  logic sys_rst,
   input  logic btn_raw,
   input  logic cfg_bypass,
   output logic btn_level,
   output logic btn_rise,
   output logic btn_fall,
   output logic glitch
);

   localparam int CNT_W = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(DB_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   db_state_t        state;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (sys_rst) begin
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         state     <= RELEASED;
         cnt       <= '0;
         btn_level <= 1'b0;
         btn_rise  <= 1'b0;
         btn_fall  <= 1'b0;
         glitch    <= 1'b0;
      end else begin
         sync1    <= btn_raw;
         sync2    <= sync1;
         btn_rise <= 1'b0;
         btn_fall <= 1'b0;
         glitch   <= 1'b0;
         if (cfg_bypass) begin
            // Park the FSM on the settled state so leaving bypass needs no requalification.
            state     <= sync2 ? PRESSED : RELEASED;
            cnt       <= '0;
            btn_level <= sync2;
            btn_rise  <= sync2 & ~btn_level;
            btn_fall  <= ~sync2 & btn_level;
         end else begin
            case (state)
               RELEASED: begin
                  if (sync2) begin
                     state <= PRESS_WAIT;
                     cnt   <= CNT_ONE;
                  end
               end
               PRESS_WAIT: begin
                  if (!sync2) begin
                     state  <= RELEASED;
                     cnt    <= '0;
                     glitch <= 1'b1;
                  end else if (cnt == CNT_TC) begin
                     state     <= PRESSED;
                     cnt       <= '0;
                     btn_level <= 1'b1;
                     btn_rise  <= 1'b1;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
               PRESSED: begin
                  if (!sync2) begin
                     state <= RELEASE_WAIT;
                     cnt   <= CNT_ONE;
                  end
               end
               RELEASE_WAIT: begin
                  if (sync2) begin
                     state  <= PRESSED;
                     cnt    <= '0;
                     glitch <= 1'b1;
                  end else if (cnt == CNT_TC) begin
                     state     <= RELEASED;
                     cnt       <= '0;
                     btn_level <= 1'b0;
                     btn_fall  <= 1'b1;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/dino_input_conditioner.sv
// Per-game button conditioner: one debounce channel per button plus a shared
// saturating count of rejected bounces for logic-analyzer debug.
module dino_input_conditioner
   import dino_input_conditioner_pkg::*;
#(
   parameter int N_CH      = 3,
   parameter int DB_CYCLES = 20000
) (
   input  logic                    clk,
   input  logic                    sys_rst,
   dino_input_conditioner_if.slave bus
);

   localparam int SUM_W = $clog2(N_CH + 1);

   logic [N_CH-1:0]     level_v;
   logic [N_CH-1:0]     rise_v;
   logic [N_CH-1:0]     fall_v;
   logic [N_CH-1:0]     glitch_v;
   logic [SUM_W-1:0]    glitch_sum;
   logic [GLITCH_W-1:0] glitch_count;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      dino_input_conditioner_debounce_channel #(
         .DB_CYCLES (DB_CYCLES)
      ) u_ch (
         .clk        (clk),
         .sys_rst    (sys_rst),
         .btn_raw    (bus.btn_raw[g]),
         .cfg_bypass (bus.cfg_bypass),
         .btn_level  (level_v[g]),
         .btn_rise   (rise_v[g]),
         .btn_fall   (fall_v[g]),
         .glitch     (glitch_v[g])
      );
   end

   always_comb begin
      glitch_sum = '0;
      for (int i = 0; i < N_CH; i++) begin
         glitch_sum = glitch_sum + SUM_W'(glitch_v[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (sys_rst) begin
         glitch_count <= '0;
      end else begin
         glitch_count <= sat_add(glitch_count, GLITCH_W'(glitch_sum));
      end
   end

   assign bus.btn_level        = level_v;
   assign bus.btn_rise         = rise_v;
   assign bus.btn_fall         = fall_v;
   assign bus.dbg_glitch_count = glitch_count;

endmodule
